// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants for the MIPS host-side debug sequencer:
//               FSM state encodings, command bytes and memory depth default.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // FSM state encodings, also presented externally on o_state
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD_CNT  = 3'd1;
    localparam logic [2:0] LOAD_DATA = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] STEP      = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    // Host command bytes (ASCII L, R, S, C)
    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_CLEAR = 8'h43;

    // Default instruction-memory depth in words
    localparam int DEFAULT_IMEM_DEPTH = 64;

endpackage
`default_nettype wire

// File: rtl/byte_to_word.sv
`default_nettype none
// ============================================================================
// Module      : byte_to_word
// Description : Assembles four MSB-first bytes into a 32-bit word. The word
//               is presented combinationally together with the 4th byte so
//               the parent can register it in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_to_word (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    // Only the three earlier bytes need storage; the 4th arrives on i_byte
    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    // Shift bytes in MSB first and count position within the word
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
        end else if (i_valid) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_valid && !i_clear && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/mips_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_debug_ctrl
// Description : Host-side sequencer for the 5-stage MIPS pipeline. Loads a
//               program from the UART byte stream into instruction memory,
//               then gates the pipeline in run or single-step mode until
//               the halt instruction retires.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_debug_ctrl
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_halt,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_loading,
    output logic                  o_pipe_enable,
    output logic [CNT_WIDTH-1:0]  o_cycle_count,
    output logic [2:0]            o_state,
    output logic                  o_done
);

    localparam logic [8:0] c_max_n = 9'(IMEM_DEPTH);

    logic [2:0]            r_state;
    logic                  r_loaded;
    logic                  r_done;
    logic                  r_pipe_enable;
    logic                  r_loading;
    logic [7:0]            r_n;
    logic [7:0]            r_word_index;
    logic [DATA_WIDTH-1:0] r_instruccion;
    logic [DATA_WIDTH-1:0] r_address;
    logic [CNT_WIDTH-1:0]  r_cycle_count;

    logic [2:0]  w_state_nxt;
    logic        w_pe_nxt;
    logic        w_done_nxt;
    logic        w_loaded_nxt;
    logic        w_count_clr;
    logic        w_b2w_clr;
    logic        w_start_load;
    logic        w_is_last;
    logic        w_halt_now;
    logic [31:0] w_word;
    logic        w_word_valid;

    byte_to_word u_byte_to_word (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (w_b2w_clr),
        .i_valid      (i_rx_valid && (r_state == LOAD_DATA)),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    assign w_is_last  = (r_word_index == (r_n - 8'd1));
    // Halt only counts during a cycle in which the pipeline actually advanced
    assign w_halt_now = r_pipe_enable && i_halt;

    // Next-state, next pipeline enable and flag updates
    always_comb begin
        w_state_nxt  = r_state;
        w_pe_nxt     = 1'b0;
        w_done_nxt   = r_done;
        w_loaded_nxt = r_loaded;
        w_count_clr  = 1'b0;
        w_b2w_clr    = 1'b0;
        w_start_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        w_state_nxt = LOAD_CNT;
                    end else if (i_rx_data == CMD_RUN && r_loaded) begin
                        w_state_nxt = RUN;
                        w_pe_nxt    = 1'b1;
                        w_count_clr = 1'b1;
                    end else if (i_rx_data == CMD_STEP && r_loaded) begin
                        // The entry S is itself the first step
                        w_state_nxt = STEP;
                        w_pe_nxt    = 1'b1;
                        w_count_clr = 1'b1;
                    end
                end
            end
            LOAD_CNT: begin
                if (i_rx_valid) begin
                    if (i_rx_data == 8'd0 || {1'b0, i_rx_data} > c_max_n) begin
                        w_state_nxt  = IDLE;
                        w_loaded_nxt = 1'b0;
                    end else begin
                        w_state_nxt  = LOAD_DATA;
                        w_b2w_clr    = 1'b1;
                        w_start_load = 1'b1;
                    end
                end
            end
            LOAD_DATA: begin
                if (w_word_valid && w_is_last) begin
                    w_state_nxt  = IDLE;
                    w_loaded_nxt = 1'b1;
                end
            end
            RUN: begin
                if (w_halt_now) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_pe_nxt = 1'b1;
                end
            end
            STEP: begin
                // A halt in the same cycle as an S byte wins; the byte is dropped
                if (w_halt_now) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else if (i_rx_valid && i_rx_data == CMD_STEP) begin
                    w_pe_nxt = 1'b1;
                end else if (i_rx_valid && i_rx_data == CMD_RUN) begin
                    w_state_nxt = RUN;
                    w_pe_nxt    = 1'b1;
                end
            end
            DONE: begin
                if (i_rx_valid && i_rx_data == CMD_CLEAR) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Control state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= IDLE;
            r_loaded      <= 1'b0;
            r_done        <= 1'b0;
            r_pipe_enable <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_loaded      <= w_loaded_nxt;
            r_done        <= w_done_nxt;
            r_pipe_enable <= w_pe_nxt;
        end
    end

    // Load datapath: word count, word index and memory write port
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_n           <= 8'd0;
            r_word_index  <= 8'd0;
            r_instruccion <= '0;
            r_address     <= '0;
            r_loading     <= 1'b0;
        end else begin
            r_loading <= w_word_valid;
            if (w_start_load) begin
                r_n          <= i_rx_data;
                r_word_index <= 8'd0;
            end
            if (w_word_valid) begin
                r_instruccion <= DATA_WIDTH'(w_word);
                r_address     <= DATA_WIDTH'({r_word_index, 2'b00});
                r_word_index  <= r_word_index + 8'd1;
            end
        end
    end

    // Saturating count of enabled pipeline cycles
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cycle_count <= '0;
        end else if (w_count_clr) begin
            r_cycle_count <= '0;
        end else if (r_pipe_enable && !(&r_cycle_count)) begin
            r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

    assign o_instruccion = r_instruccion;
    assign o_address     = r_address;
    assign o_loading     = r_loading;
    assign o_pipe_enable = r_pipe_enable;
    assign o_cycle_count = r_cycle_count;
    assign o_state       = r_state;
    assign o_done        = r_done;

endmodule
`default_nettype wire

// File: doc/mips_debug_ctrl.md
# mips_debug_ctrl

Host-side sequencer for the 5-stage MIPS pipeline. Consumes a byte stream from the UART receiver, assembles 32-bit instruction words and writes them into instruction memory through the fetch stage's load port. It then gates the pipeline in free-run or single-step mode until the program's halt instruction retires. Sits between the UART RX and the top-level pipeline; owns the pipeline clock-enable and the load strobe.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction/address width
- IMEM_DEPTH, 64, max words per load; word count N must satisfy 1..IMEM_DEPTH
- CNT_WIDTH, 32, cycle-counter width

Ports:
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_halt  in  1  halt instruction at WB stage (from pipeline)
- o_instruccion  out  DATA_WIDTH  assembled word to fetch-stage load port
- o_address  out  DATA_WIDTH  byte address of o_instruccion (word_index*4)
- o_loading  out  1  one-cycle instruction-memory write strobe
- o_pipe_enable  out  1  pipeline advance enable
- o_cycle_count  out  CNT_WIDTH  enabled cycles since last run/step start
- o_state  out  3  current FSM state
- o_done  out  1  program halted

## Operation
- Command bytes: L=0x4C load, R=0x52 run, S=0x53 step, C=0x43 clear. Unknown bytes are ignored in every state.
- States (o_state encoding):
  - IDLE=0: L→LOAD_CNT. R→RUN or S→STEP only if the loaded flag is set; otherwise ignored. R/S clear o_cycle_count.
  - LOAD_CNT=1: next byte is N.
    - N=0 or N>IMEM_DEPTH → IDLE; loaded flag cleared.
    - Otherwise word_index=0, byte_cnt=0 → LOAD_DATA.
  - LOAD_DATA=2: every byte is data, MSB first.
    - On the 4th byte: o_instruccion = assembled word, o_address = word_index<<2, o_loading pulses, word_index++.
    - After word N-1: set loaded flag → IDLE.
    - Command values are data here, not decoded.
  - RUN=3: o_pipe_enable=1 every cycle. i_halt=1 while enabled → DONE. Rx bytes ignored.
  - STEP=4: each S byte produces exactly one o_pipe_enable cycle. R → RUN. i_halt=1 during an enabled cycle → DONE.
  - DONE=5: o_pipe_enable=0, o_done=1. C → IDLE; o_done cleared, loaded flag kept. Other bytes ignored.
- o_cycle_count increments on every cycle with o_pipe_enable=1 and saturates at all-ones.
- i_halt is ignored when o_pipe_enable=0.
- STEP, same cycle as i_halt (enabled) and rx S: halt wins, byte dropped.
- LOAD_DATA has no timeout; a stream stall holds state indefinitely.

## Timing
- All outputs registered.
- Reset values: o_instruccion=0, o_address=0, o_loading=0, o_pipe_enable=0, o_cycle_count=0, o_state=IDLE, o_done=0; loaded flag=0.
- Reset mid-load aborts immediately; partial words are not written.
- Load: o_loading high exactly 1 cycle, the cycle after the 4th byte's i_rx_valid. Data/address are stable in that cycle and held until the next write.
- RUN entry: o_pipe_enable=1 the cycle after R is accepted.
- RUN exit: o_pipe_enable=0 the cycle after i_halt sampled high. Exactly one enabled cycle follows i_halt being asserted (the halt cycle itself).
- STEP: o_pipe_enable=1 in the cycle after the S strobe, for 1 cycle. The entry S from IDLE counts as the first step.
- Back-to-back i_rx_valid every cycle is supported in all states.

## Structure
- Shared package mips_pkg:
  - state encodings (localparams IDLE..DONE)
  - command byte constants CMD_LOAD/RUN/STEP/CLEAR
  - IMEM_DEPTH default
- One sub-module: byte_to_word.
  - 4-byte MSB-first shift register with 2-bit byte counter and clear input.
  - Emits word_valid on the 4th byte.
  - FSM, word index, cycle counter and halt logic stay in mips_debug_ctrl.

## Test plan
- Load N=2, bytes 00 11 22 33 AA BB CC DD → o_loading pulses twice: 0x00112233@0x0, then 0xAABBCCDD@0x4; state returns to IDLE.
- R with nothing loaded → stays IDLE, o_pipe_enable=0. L then N=0 → IDLE, loaded flag still 0.
- Load 1 word, R, assert i_halt on 10th enabled cycle → o_pipe_enable drops next cycle, o_cycle_count=10, o_done=1, o_state=5.
- STEP: S, S, S with gaps → exactly 3 single-cycle enables, o_cycle_count=3. R → continuous enable until halt. C → IDLE, o_done=0.
- In STEP, i_halt and rx S coincide → DONE, no extra enable. Reset asserted mid LOAD_DATA (2 of 4 bytes) → all outputs at reset values, no o_loading pulse.
